// File: rtl/aes_package.sv
// Shared constants for the AES TCDM test responder: stall LFSR taps,
// statistics counter width and the tcdm_wen encoding.
package aes_package;

  localparam int CNT_W = 16;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting toward the MSB: taps on bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic TCDM_WEN_READ  = 1'b1;
  localparam logic TCDM_WEN_WRITE = 1'b0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/aes_tcdm_rr_arbiter.sv
// MP-way round-robin arbiter: combinational grant, registered last-granted pointer.
// block_i suppresses every grant and freezes the pointer.
module aes_tcdm_rr_arbiter #(
  parameter int MP = 2,
  localparam int IDX_W = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [MP-1:0]    req_i,
  input  logic             block_i,
  output logic [MP-1:0]    gnt_o,
  output logic             gnt_any_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int               cand;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    found    = 1'b0;
    win      = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= MP; k++) begin
      cand     = (int'(last_q) + k) % MP;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_any_o   = found & ~block_i;
    gnt_idx_o   = win;
    gnt_o       = '0;
    gnt_o[win]  = gnt_any_o;
    last_d      = gnt_any_o ? win : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(MP - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/aes_tcdm_responder.sv
// Single-ported TCDM memory model for the AES accelerator testbenches:
// round-robin arbitration across MP slave ports, optional random grant stalls.
module aes_tcdm_responder
  import aes_package::*;
#(
  parameter int         MP        = 2,
  parameter int         DEPTH     = 1024,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MP-1:0]         tcdm_req,
  output logic [MP-1:0]         tcdm_gnt,
  input  logic [MP-1:0][31:0]   tcdm_add,
  input  logic [MP-1:0]         tcdm_wen,
  input  logic [MP-1:0][3:0]    tcdm_be,
  input  logic [MP-1:0][31:0]   tcdm_data,
  output logic [MP-1:0][31:0]   tcdm_r_data,
  output logic [MP-1:0]         tcdm_r_valid,
  input  logic                  stall_en_i,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = (MP > 1) ? $clog2(MP) : 1;

  logic [7:0]             lfsr_q;
  logic                   stall;
  logic                   gnt_any;
  logic [IDX_W-1:0]       gnt_idx;
  logic [31:0]            sel_add;
  logic [31:0]            sel_data;
  logic [3:0]             sel_be;
  logic                   sel_wen;
  logic [AW-1:0]          word;
  logic                   rd_gnt;
  logic                   wr_gnt;
  logic                   unused_add;

  logic [31:0]            mem_q [DEPTH];
  logic [MP-1:0][31:0]    r_data_q;
  logic [MP-1:0]          r_valid_q;
  logic [CNT_W-1:0]       rd_cnt_q;
  logic [CNT_W-1:0]       wr_cnt_q;

  assign stall = stall_en_i & lfsr_q[0];

  aes_tcdm_rr_arbiter #(
    .MP (MP)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (tcdm_req),
    .block_i   (rst_i | stall),
    .gnt_o     (tcdm_gnt),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_add  = tcdm_add[gnt_idx];
  assign sel_data = tcdm_data[gnt_idx];
  assign sel_be   = tcdm_be[gnt_idx];
  assign sel_wen  = tcdm_wen[gnt_idx];

  // Upper address bits alias onto the array; the byte offset is ignored.
  assign word       = sel_add[AW+1:2];
  assign unused_add = ^{sel_add[31:AW+2], sel_add[1:0]};

  assign rd_gnt = gnt_any & (sel_wen == TCDM_WEN_READ);
  assign wr_gnt = gnt_any & (sel_wen == TCDM_WEN_WRITE);

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_gnt) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem_q[word][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q    <= LFSR_SEED;
      r_valid_q <= '0;
      r_data_q  <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      lfsr_q    <= lfsr_next(lfsr_q);
      r_valid_q <= '0;
      if (rd_gnt) begin
        r_valid_q[gnt_idx] <= 1'b1;
        r_data_q[gnt_idx]  <= mem_q[word];
        rd_cnt_q           <= rd_cnt_q + CNT_W'(1);
      end
      if (wr_gnt) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // A read granted just before reset must not surface while reset is high.
  assign tcdm_r_valid = r_valid_q & {MP{~rst_i}};
  assign tcdm_r_data  = r_data_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// Self-checking bench for aes_tcdm_responder: driver tasks, a negedge monitor
// with a read-data scoreboard, a reference memory and a reference stall LFSR.
module tb_aes_tcdm_responder;

  localparam int MP    = 2;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [MP-1:0]       req = '0;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add = '0;
  logic [MP-1:0]       wen = '1;
  logic [MP-1:0][3:0]  be_s = '0;
  logic [MP-1:0][31:0] wdata = '0;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;
  logic                stall_en = 1'b0;
  logic [15:0]         rd_cnt;
  logic [15:0]         wr_cnt;

  always #5 clk = ~clk;

  aes_tcdm_responder #(
    .MP        (MP),
    .DEPTH     (DEPTH),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tcdm_req     (req),
    .tcdm_gnt     (gnt),
    .tcdm_add     (add),
    .tcdm_wen     (wen),
    .tcdm_be      (be_s),
    .tcdm_data    (wdata),
    .tcdm_r_data  (r_data),
    .tcdm_r_valid (r_valid),
    .stall_en_i   (stall_en),
    .rd_cnt_o     (rd_cnt),
    .wr_cnt_o     (wr_cnt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] hold_exp [MP];
  logic        pend_v = 1'b0;
  int          pend_p = 0;
  int          rd_exp = 0;
  int          wr_exp = 0;
  logic [7:0]  m_lfsr = 8'h01;
  logic        exp_rv;
  int          mw;
  logic [31:0] mword;
  logic [31:0] popped;
  int          lat;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference stall LFSR: x^8+x^6+x^5+x^4+1, restarted from the seed by reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'h01;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge clk) begin : monitor
    for (int p = 0; p < MP; p++) begin
      exp_rv = pend_v && (pend_p == p) && !rst;
      check($sformatf("rvalid_p%0d", p), 32'(r_valid[p]), 32'(exp_rv));
      if (rst) begin
        if (pend_v && pend_p == p && exp_q.size() > 0) popped = exp_q.pop_front();
        hold_exp[p] = '0;
      end else if (exp_rv) begin
        popped = exp_q.pop_front();
        check($sformatf("rdata_p%0d", p), r_data[p], popped);
        hold_exp[p] = popped;
      end else begin
        check($sformatf("rdata_hold_p%0d", p), r_data[p], hold_exp[p]);
      end
    end

    pend_v = 1'b0;
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    if (rst) begin
      check("gnt_in_reset", 32'(gnt), 32'd0);
      rd_exp = 0;
      wr_exp = 0;
    end else begin
      if (stall_en && m_lfsr[0]) check("gnt_in_stall", 32'(gnt), 32'd0);
      for (int p = 0; p < MP; p++) begin
        if (gnt[p]) begin
          check("gnt_without_req", 32'(req[p]), 32'd1);
          mw = int'(add[p][AW+1:2]);
          mword = model_mem.exists(mw) ? model_mem[mw] : 32'h0;
          if (wen[p]) begin
            exp_q.push_back(mword);
            pend_v = 1'b1;
            pend_p = p;
            rd_exp++;
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (be_s[p][b]) mword[8*b +: 8] = wdata[p][8*b +: 8];
            end
            model_mem[mw] = mword;
            wr_exp++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // Raise one request and hold it until granted; returns stalled cycles.
  task automatic access(input int p, input logic wen_v, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int waited);
    bit got = 0;
    waited = 0;
    req[p] = 1'b1; wen[p] = wen_v; add[p] = a; be_s[p] = be; wdata[p] = d;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (gnt[p]) got = 1;
      else        waited++;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(rd_exp));
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(wr_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    logic [31:0] a;
    logic        is_rd;

    // Reset with a request pending: no grant may appear.
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h10;
    rst = 1'b1;
    idle(3);
    req[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_rdata0", r_data[0], 32'd0);
    check("rst_rdata1", r_data[1], 32'd0);
    check("rst_rvalid", 32'(r_valid), 32'd0);
    @(posedge clk);
    #1;

    // Basic write then read.
    access(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, lat);
    check("wr_gnt_latency", 32'(lat), 32'd0);
    access(0, 1'b1, 32'h10, 4'hF, 32'h0, lat);
    check("rd_gnt_latency", 32'(lat), 32'd0);
    @(negedge clk);
    check("basic_rvalid", 32'(r_valid[0]), 32'd1);
    check("basic_rdata", r_data[0], 32'hDEADBEEF);
    @(posedge clk);
    #1;
    check_counts("basic");
    check("basic_wr_is_1", 32'(wr_cnt), 32'd1);
    check("basic_rd_is_1", 32'(rd_cnt), 32'd1);

    // Byte-enable merge.
    access(0, 1'b0, 32'h20, 4'hF, 32'h11223344, lat);
    access(1, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, lat);
    access(1, 1'b1, 32'h20, 4'hF, 32'h0, lat);
    @(negedge clk);
    check("be_rdata", r_data[1], 32'h11BB33DD);
    @(posedge clk);
    #1;

    // Read-before-write and write-before-read on the same word, back to back.
    access(0, 1'b1, 32'h20, 4'hF, 32'h0, lat);
    access(1, 1'b0, 32'h20, 4'hF, 32'hCAFEF00D, lat);
    access(0, 1'b1, 32'h20, 4'hF, 32'h0, lat);
    @(negedge clk);
    check("raw_rdata", r_data[0], 32'hCAFEF00D);
    @(posedge clk);
    #1;

    // Aliasing of high address bits and byte offset.
    access(1, 1'b0, 32'(4 * DEPTH + 8), 4'hF, 32'h5, lat);
    access(0, 1'b1, 32'h8 | 32'h3, 4'hF, 32'h0, lat);
    @(negedge clk);
    check("alias_rdata", r_data[0], 32'h5);
    @(posedge clk);
    #1;

    // Random single-port traffic, stalls off.
    for (int i = 0; i < 24; i++) begin
      w = $urandom_range(0, 15);
      a = 32'h100 + 32'(4 * w) + (32'($urandom_range(0, 3)) << (AW + 2)) + 32'($urandom_range(0, 3));
      is_rd = model_mem.exists(64 + w) ? 1'($urandom_range(0, 1)) : 1'b0;
      access($urandom_range(0, 1), is_rd, a,
             model_mem.exists(64 + w) ? 4'($urandom_range(1, 15)) : 4'hF, $urandom, lat);
    end
    idle(2);
    check_counts("rand");

    // Round-robin with both ports requesting from reset.
    access(0, 1'b0, 32'h40, 4'hF, 32'hA0A0A0A0, lat);
    access(1, 1'b0, 32'h44, 4'hF, 32'hB1B1B1B1, lat);
    idle(1);
    do_reset(2);
    req = 2'b11; wen = 2'b11; add[0] = 32'h40; add[1] = 32'h44;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("arb_cycle%0d", c), 32'(gnt), (c % 2 == 0) ? 32'd1 : 32'd2);
    end
    @(posedge clk);
    #1;
    req = '0;
    idle(2);
    check_counts("arb");

    // Pseudo-random stalls: start in a stalled cycle so at least one is seen.
    do_reset(2);
    stall_en = 1'b1;
    for (int c = 0; c < 64 && !m_lfsr[0]; c++) idle(1);
    access(0, 1'b1, 32'h10, 4'hF, 32'h0, lat);
    check("stall_seen", 32'(lat > 0), 32'd1);
    @(negedge clk);
    check("stall_rdata", r_data[0], 32'hDEADBEEF);
    @(posedge clk);
    #1;
    check_counts("stall");
    check("stall_rd_is_1", 32'(rd_cnt), 32'd1);

    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(0, 15);
      is_rd = model_mem.exists(64 + w) ? 1'($urandom_range(0, 1)) : 1'b0;
      access($urandom_range(0, 1), is_rd, 32'h100 + 32'(4 * w), 4'hF, $urandom, lat);
    end
    stall_en = 1'b0;
    idle(2);
    check_counts("stall_rand");

    // Reset the cycle after a read grant: response dropped, memory kept.
    access(0, 1'b0, 32'h50, 4'hF, 32'h00000077, lat);
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h50;
    @(negedge clk);
    check("rst_mid_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_mid_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_mid_wr_cnt", 32'(wr_cnt), 32'd0);
    @(posedge clk);
    #1;
    access(1, 1'b1, 32'h50, 4'hF, 32'h0, lat);
    @(negedge clk);
    check("rst_mid_mem_kept", r_data[1], 32'h00000077);
    @(posedge clk);
    #1;

    idle(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
